// File: rtl/mem_port_arbiter.sv
// Store/load arbiter in front of the data cache.
// Loads that miss are filled from backing memory and then answered.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 3,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic             st_size,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [31:0]      ld_addr,
  input  logic             ld_size,
  input  logic [TAG_W-1:0] ld_tag,
  output logic             ld_resp_valid,
  output logic [31:0]      ld_resp_data,
  output logic [TAG_W-1:0] ld_resp_tag,
  output logic             c_memRead,
  output logic             c_memWrite,
  output logic [31:0]      c_addr,
  output logic [31:0]      c_data,
  output logic             c_size,
  input  logic [31:0]      c_lw_data,
  input  logic             c_miss,
  output logic             m_req,
  output logic [31:0]      m_addr,
  input  logic             m_ack,
  input  logic [31:0]      m_rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 2);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    IDLE, ST_ISSUE, LD_ISSUE, LD_CHECK,
    MEM_WAIT, FILL, LD_RESP
  } state_t;

  state_t           state;
  logic [SW-1:0]    streak;
  logic [31:0]      addr_q;
  logic             size_q;
  logic [TAG_W-1:0] tag_q;
  logic             idle;
  logic             ld_win;

  function automatic logic [31:0] zext(
    input logic [31:0] d,
    input logic        sz
  );
    return sz ? {24'b0, d[7:0]} : {16'b0, d[15:0]};
  endfunction

  // A waiting load takes the port once stores have starved it long enough.
  assign idle     = rstn && (state == IDLE);
  assign ld_win   = ld_valid && (!st_valid || streak == LIM);
  assign ld_ready = idle && ld_win;
  assign st_ready = idle && st_valid && !ld_win;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      streak        <= '0;
      addr_q        <= '0;
      size_q        <= 1'b0;
      tag_q         <= '0;
      ld_resp_valid <= 1'b0;
      ld_resp_data  <= '0;
      ld_resp_tag   <= '0;
      c_memRead     <= 1'b0;
      c_memWrite    <= 1'b0;
      c_addr        <= '0;
      c_data        <= '0;
      c_size        <= 1'b0;
      m_req         <= 1'b0;
      m_addr        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!ld_valid || ld_ready)
            streak <= '0;
          else if (st_ready && streak != LIM)
            streak <= streak + 1'b1;
          if (ld_ready) begin
            state     <= LD_ISSUE;
            addr_q    <= ld_addr;
            size_q    <= ld_size;
            tag_q     <= ld_tag;
            c_memRead <= 1'b1;
            c_addr    <= ld_addr;
            c_size    <= ld_size;
          end else if (st_ready) begin
            state      <= ST_ISSUE;
            c_memWrite <= 1'b1;
            c_addr     <= st_addr;
            c_data     <= st_data;
            c_size     <= st_size;
          end
        end
        ST_ISSUE: begin
          c_memWrite <= 1'b0;
          state      <= IDLE;
        end
        LD_ISSUE: begin
          c_memRead <= 1'b0;
          state     <= LD_CHECK;
        end
        LD_CHECK: begin
          if (c_miss) begin
            m_req  <= 1'b1;
            m_addr <= addr_q;
            state  <= MEM_WAIT;
          end else begin
            ld_resp_valid <= 1'b1;
            ld_resp_data  <= zext(c_lw_data, size_q);
            ld_resp_tag   <= tag_q;
            state         <= LD_RESP;
          end
        end
        MEM_WAIT: begin
          if (m_ack) begin
            m_req      <= 1'b0;
            c_memWrite <= 1'b1;
            c_addr     <= addr_q;
            c_data     <= m_rdata;
            c_size     <= size_q;
            state      <= FILL;
          end
        end
        FILL: begin
          c_memWrite    <= 1'b0;
          ld_resp_valid <= 1'b1;
          ld_resp_data  <= zext(c_data, size_q);
          ld_resp_tag   <= tag_q;
          state         <= LD_RESP;
        end
        LD_RESP: begin
          ld_resp_valid <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
